// File: rtl/rf_ctrl_pkg.sv
// Shared widths and enums for the register-file write-port sequencer.
package rf_ctrl_pkg;
  localparam int REG_AW   = 5;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;

  typedef enum logic {COUNT = 1'b0, CAPTURE = 1'b1} scan_state_e;
  typedef enum logic {REQ_WB = 1'b0, REQ_DBG = 1'b1} req_id_e;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; grant bit index matches req_id_e.
module rr_arb2
  import rf_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  req_id_e rr_last;

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      // tie goes to whoever was not granted last
      2'b11:   grant = (rr_last == REQ_WB) ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn)                   rr_last <= REQ_WB;
    else if (advance && |grant)  rr_last <= grant[1] ? REQ_DBG : REQ_WB;
  end

endmodule

// File: rtl/rf_access_ctrl.sv
// Shares the register-file write port between CPU writeback and debug writes,
// and scans the spare read port into the 7-segment display capture registers.
module rf_access_ctrl
  import rf_ctrl_pkg::*;
#(
  parameter int SCAN_DIV = 25_000_000,
  parameter int CNT_W    = $clog2(SCAN_DIV)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              freeze,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              dbg_valid,
  output logic              dbg_ready,
  input  logic [REG_AW-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_data,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_wa,
  output logic [DATA_W-1:0] rf_wd,
  output logic [REG_AW-1:0] rf_ra,
  input  logic [DATA_W-1:0] rf_rd,
  input  logic              scan_en,
  output logic [REG_AW-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_stb
);

  logic [1:0]        req, grant;
  logic              xfer;
  logic [REG_AW-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  scan_state_e       state;
  logic [CNT_W-1:0]  div;

  assign req = {dbg_valid, wb_valid & ~freeze};

  rr_arb2 u_arb (
    .clk     (clk),
    .rstn    (rstn),
    .req     (req),
    .advance (xfer),
    .grant   (grant)
  );

  assign wb_ready  = rstn & grant[0];
  assign dbg_ready = rstn & grant[1];
  assign xfer      = wb_ready | dbg_ready;
  assign sel_addr  = wb_ready ? wb_addr : dbg_addr;
  assign sel_data  = wb_ready ? wb_data : dbg_data;

  // x0 transfers complete the handshake but never reach the register file
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rf_we <= 1'b0;
      rf_wa <= '0;
      rf_wd <= '0;
    end else if (xfer && sel_addr != '0) begin
      rf_we <= 1'b1;
      rf_wa <= sel_addr;
      rf_wd <= sel_data;
    end else begin
      rf_we <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= COUNT;
      div       <= '0;
      rf_ra     <= '0;
      disp_addr <= '0;
      disp_data <= '0;
      disp_stb  <= 1'b0;
    end else begin
      disp_stb <= 1'b0;
      case (state)
        COUNT: if (scan_en) begin
          if (div == CNT_W'(SCAN_DIV - 1)) begin
            div   <= '0;
            state <= CAPTURE;
          end else begin
            div <= div + 1'b1;
          end
        end
        default: begin
          disp_addr <= rf_ra;
          // a write issued last cycle is not yet visible on rf_rd
          disp_data <= (rf_we && rf_wa == rf_ra) ? rf_wd : rf_rd;
          disp_stb  <= 1'b1;
          rf_ra     <= rf_ra + 1'b1;
          state     <= COUNT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rf_access_ctrl.sv
// Randomized bench for rf_access_ctrl against a cycle-level behavioural model.
module tb_rf_access_ctrl;
  localparam int SCAN_DIV = 4;

  logic        clk = 1'b0;
  logic        rstn, freeze, wb_valid, dbg_valid, scan_en;
  logic [4:0]  wb_addr, dbg_addr;
  logic [31:0] wb_data, dbg_data;
  logic        wb_ready, dbg_ready, rf_we, disp_stb;
  logic [4:0]  rf_wa, rf_ra, disp_addr;
  logic [31:0] rf_wd, rf_rd, disp_data;

  logic [31:0] rf_mem [32];
  logic [31:0] m_mem  [32];

  int n_cmp = 0;
  int n_err = 0;

  // model state: expected registered outputs plus scan bookkeeping
  logic        x_we, x_stb, m_pend;
  logic [4:0]  x_wa, x_da, m_ptr;
  logic [31:0] x_wd, x_dd;
  int          m_cnt, m_last;

  always #5 clk = ~clk;

  rf_access_ctrl #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk(clk), .rstn(rstn), .freeze(freeze),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
    .dbg_valid(dbg_valid), .dbg_ready(dbg_ready), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd), .rf_ra(rf_ra), .rf_rd(rf_rd),
    .scan_en(scan_en), .disp_addr(disp_addr), .disp_data(disp_data), .disp_stb(disp_stb)
  );

  // register-file environment driven by the DUT
  assign rf_rd = rf_mem[rf_ra];
  always @(posedge clk) if (rf_we) rf_mem[rf_wa] <= rf_wd;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic rv, input logic frz, input logic wv, input logic [4:0] wa,
                      input logic [31:0] wd, input logic dv, input logic [4:0] da,
                      input logic [31:0] dd, input logic sen);
    logic g_wb, g_dbg, e_wb, n_we, n_stb, n_pend;
    logic [4:0]  n_wa, n_da, n_ptr, a;
    logic [31:0] n_wd, n_dd, d;
    int n_cnt, n_last;
    @(negedge clk);
    chk("rf_we", {31'd0, rf_we}, {31'd0, x_we});
    chk("rf_wa", {27'd0, rf_wa}, {27'd0, x_wa});
    chk("rf_wd", rf_wd, x_wd);
    chk("rf_ra", {27'd0, rf_ra}, {27'd0, m_ptr});
    chk("disp_stb", {31'd0, disp_stb}, {31'd0, x_stb});
    chk("disp_addr", {27'd0, disp_addr}, {27'd0, x_da});
    chk("disp_data", disp_data, x_dd);
    rstn = rv; freeze = frz; scan_en = sen;
    wb_valid = wv; wb_addr = wa; wb_data = wd;
    dbg_valid = dv; dbg_addr = da; dbg_data = dd;
    #1;
    e_wb = wv & ~frz;
    if (!rv)            begin g_wb = 0; g_dbg = 0; end
    else if (e_wb && dv) begin g_dbg = (m_last == 0); g_wb = ~g_dbg; end
    else                begin g_wb = e_wb; g_dbg = dv; end
    chk("wb_ready", {31'd0, wb_ready}, {31'd0, g_wb});
    chk("dbg_ready", {31'd0, dbg_ready}, {31'd0, g_dbg});

    n_we = 0; n_wa = x_wa; n_wd = x_wd; n_stb = 0; n_da = x_da; n_dd = x_dd;
    n_ptr = m_ptr; n_cnt = m_cnt; n_pend = m_pend; n_last = m_last;
    if (!rv) begin
      n_wa = 0; n_wd = 0; n_da = 0; n_dd = 0; n_ptr = 0; n_cnt = 0; n_pend = 0; n_last = 0;
    end else begin
      if (g_wb || g_dbg) begin
        a = g_wb ? wa : da;
        d = g_wb ? wd : dd;
        n_last = g_dbg ? 1 : 0;
        if (a != 0) begin n_we = 1; n_wa = a; n_wd = d; end
      end
      if (m_pend) begin
        n_stb = 1; n_da = m_ptr;
        n_dd = (x_we && x_wa == m_ptr) ? x_wd : m_mem[m_ptr];
        n_ptr = m_ptr + 5'd1; n_pend = 0;
      end else if (sen) begin
        n_cnt = m_cnt + 1;
        if (n_cnt == SCAN_DIV) begin n_cnt = 0; n_pend = 1; end
      end
    end
    @(posedge clk);
    if (x_we) m_mem[x_wa] = x_wd;
    x_we = n_we; x_wa = n_wa; x_wd = n_wd; x_stb = n_stb; x_da = n_da; x_dd = n_dd;
    m_ptr = n_ptr; m_cnt = n_cnt; m_pend = n_pend; m_last = n_last;
  endtask

  task automatic idle(input logic sen);
    step(1, 0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, sen);
  endtask

  initial begin
    logic found;
    logic [4:0] hold_ptr;
    for (int i = 0; i < 32; i++) begin rf_mem[i] = i; m_mem[i] = i; end
    x_we = 0; x_wa = 0; x_wd = 0; x_stb = 0; x_da = 0; x_dd = 0;
    m_ptr = 0; m_cnt = 0; m_pend = 0; m_last = 0;
    rstn = 0; freeze = 0; scan_en = 1; wb_valid = 1; dbg_valid = 1;
    wb_addr = 5; wb_data = 0; dbg_addr = 6; dbg_data = 0;
    @(posedge clk);

    // reset with both valids asserted
    repeat (3) step(0, 0, 1, 5'd5, 32'h1, 1, 5'd6, 32'h2, 1);

    // contention: dbg, wb, dbg, wb
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 1, 5'd5, 32'hAAAA0005, 1, 5'd6, 32'h12345678, 1);
      #1;
      chk("contend_wa", {27'd0, rf_wa}, (i % 2 == 0) ? 32'd6 : 32'd5);
      chk("contend_wd", rf_wd, (i % 2 == 0) ? 32'h12345678 : 32'hAAAA0005);
    end

    // freeze holds off writeback, release grants it immediately
    repeat (5) step(1, 1, 1, 5'd7, 32'h77, 0, 5'd0, 32'd0, 1);
    step(1, 0, 1, 5'd7, 32'h77, 0, 5'd0, 32'd0, 1);
    #1;
    chk("frz_we", {31'd0, rf_we}, 32'd1);
    chk("frz_wa", {27'd0, rf_wa}, 32'd7);
    chk("frz_wd", rf_wd, 32'h77);

    // x0 write is accepted but dropped
    step(1, 0, 0, 5'd0, 32'd0, 1, 5'd0, 32'hDEADBEEF, 1);
    #1;
    chk("x0_we", {31'd0, rf_we}, 32'd0);

    // mid-operation reset discards a pending write and restarts the scan
    step(1, 0, 1, 5'd9, 32'h99, 0, 5'd0, 32'd0, 1);
    step(0, 0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1);
    #1;
    chk("rst_we", {31'd0, rf_we}, 32'd0);
    chk("rst_ra", {27'd0, rf_ra}, 32'd0);

    // bypass: write r3 so it is in flight during the r3 capture
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (m_ptr == 3 && !m_pend && m_cnt == SCAN_DIV - 1) found = 1;
      else idle(1);
    end
    chk("bypass_sync", {31'd0, found}, 32'd1);
    step(1, 0, 1, 5'd3, 32'hCAFE, 0, 5'd0, 32'd0, 1);
    idle(1);
    #1;
    chk("bypass_stb", {31'd0, disp_stb}, 32'd1);
    chk("bypass_addr", {27'd0, disp_addr}, 32'd3);
    chk("bypass_data", disp_data, 32'hCAFE);

    // full scan wrap past r31
    repeat (170) idle(1);

    // scan_en low freezes the pointer (after any capture already due)
    idle(0);
    hold_ptr = m_ptr;
    repeat (12) idle(0);
    #1;
    chk("scan_hold", {27'd0, rf_ra}, {27'd0, hold_ptr});

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(0, 199) != 0), ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), $urandom,
           ($urandom_range(0, 2) != 0), 5'($urandom_range(0, 31)), $urandom,
           ($urandom_range(0, 4) != 0));
    end
    idle(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rf_access_ctrl.md
# rf_access_ctrl

Sequencer and arbiter for the 32×32 CPU register file's single write port and its spare read port. It shares the write port between CPU writeback and switch-driven debug writes using round-robin, and blocks CPU writeback while the freeze switch is set. It also auto-scans r0..r31 through the spare read port to feed the 7-segment display. It sits between the CPU core, the board switch/button logic and the register file.

## Interface
Parameters:
- SCAN_DIV, 25_000_000: clk cycles between successive display captures; legal range ≥ 2.
- CNT_W, $clog2(SCAN_DIV): width of the scan divider counter.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rstn  in  1  reset, synchronous, active-low.
- freeze  in  1  board switch; 1 = CPU writeback blocked.
- wb_valid  in  1  CPU writeback request.
- wb_ready  out  1  writeback accepted this cycle.
- wb_addr  in  5  writeback destination register.
- wb_data  in  32  writeback data.
- dbg_valid  in  1  debug write request.
- dbg_ready  out  1  debug write accepted this cycle.
- dbg_addr  in  5  debug destination register.
- dbg_data  in  32  debug write data.
- rf_we  out  1  register-file write enable.
- rf_wa  out  5  register-file write address.
- rf_wd  out  32  register-file write data.
- rf_ra  out  5  register-file spare read address (scan pointer).
- rf_rd  in  32  combinational read data for rf_ra.
- scan_en  in  1  1 = scan pointer advances.
- disp_addr  out  5  register number of the captured value.
- disp_data  out  32  captured register value.
- disp_stb  out  1  one-cycle pulse when disp_* updates.

## Operation
- Handshake: transfer when valid & ready. valid must not depend on ready. ready is a combinational function of both valids, freeze and rr_last.
- Eligibility: wb eligible = wb_valid & ~freeze; dbg eligible = dbg_valid.
- Arbitration: one grant per cycle.
  - If only one requester is eligible, it is granted.
  - If both are eligible, the requester not granted last is granted; rr_last records it.
  - rr_last changes only on a transfer. Reset value: wb was last, so dbg wins the first tie.
- Write issue: a granted transfer registers rf_we=1, rf_wa=addr, rf_wd=data on the next edge. Otherwise rf_we=0; rf_wa and rf_wd hold their values.
- x0 writes: handshake completes but rf_we stays 0 (dropped).
- freeze only gates wb_ready. dbg writes and scanning continue. A wb request held during freeze is granted in the first cycle freeze is 0.
- Scan FSM, states COUNT and CAPTURE:
  - COUNT: div increments while scan_en=1 and holds while scan_en=0. When div reaches SCAN_DIV-1, div is cleared and the FSM moves to CAPTURE.
  - CAPTURE: one cycle. Loads disp_addr=rf_ra and disp_data=rf_rd, pulses disp_stb, advances rf_ra+1 (31 wraps to 0), and returns to COUNT.
- Capture bypass: if rf_we=1 and rf_wa==rf_ra in the CAPTURE cycle, disp_data takes rf_wd. The register file has not committed that write yet.
- Reset values: wb_ready and dbg_ready are combinational and read 0 while rstn=0. rf_we=0, rf_wa=0, rf_wd=0, rf_ra=0, disp_addr=0, disp_data=0, disp_stb=0, div=0, state=COUNT, rr_last=wb.
- Reset mid-operation: a registered write not yet committed is discarded (rf_we forced 0). The scan restarts at r0.

## Timing
- Handshake to rf_we: 1 cycle. Register-file commit is at the following edge.
- Throughput: one write per cycle total across both requesters.
- With both requesters permanently eligible, grants strictly alternate.
- Scan: first disp_stb occurs SCAN_DIV+1 cycles after rstn rises with scan_en=1. Period is SCAN_DIV+1 cycles per register.
- disp_stb is high exactly one cycle per capture.

## Structure
- Package rf_ctrl_pkg holds:
  - REG_AW=5, DATA_W=32, NUM_REGS=32.
  - Scan state enum {COUNT, CAPTURE}.
  - Requester id enum {REQ_WB, REQ_DBG}.
- Sub-module rr_arb2 is a 2-way round-robin arbiter holding rr_last. Inputs: clk, rstn, req[1:0], advance. Output: one-hot grant[1:0]. Write-port registering and the scan FSM stay in rf_access_ctrl.

## Test plan
- Reset: hold rstn=0 for 3 cycles with both valids high → both readys 0, rf_we=0, rf_ra=0, disp_stb=0.
- Contention: wb (r5, 0xAAAA0005) and dbg (r6, 0x12345678) held valid 4 cycles → grants dbg, wb, dbg, wb. rf_we=1 each following cycle with matching addr/data.
- Freeze: freeze=1, wb_valid (r7, 0x77) for 5 cycles → wb_ready=0 throughout. Release freeze → wb_ready=1 that cycle, then rf_we=1, rf_wa=7, rf_wd=0x77.
- x0 drop: dbg write r0=0xDEADBEEF → dbg_ready=1 and rf_we stays 0.
- Scan wrap: SCAN_DIV=4, register-file model holds ri=i → disp_stb every 5 cycles with disp_addr 0,1,…,31,0 and disp_data=disp_addr. scan_en=0 freezes the pointer.
- Bypass: SCAN_DIV=4, time a wb write r3=0xCAFE so rf_we=1 with rf_wa=3 in the CAPTURE cycle for r3 → disp_data=0xCAFE, not the stale value.
